// File: rtl/rename_unit_if.sv
// Rename stage bundle types and the decode/dispatch/commit interface.
// uop fields rs1/rs2/rd are wide enough for physical indices.
package rename_pkg;
  localparam int LOG_DEPTH = 32;
  localparam int PHY_DEPTH = 128;
  localparam int LOG_W = $clog2(LOG_DEPTH);
  localparam int PHY_W = $clog2(PHY_DEPTH);

  typedef struct packed {
    logic [15:0]      imm;
    logic [5:0]       op;
    logic             rs1_valid;
    logic [PHY_W-1:0] rs1;
    logic             rs2_valid;
    logic [PHY_W-1:0] rs2;
    logic             rd_valid;
    logic [PHY_W-1:0] rd;
  } uop_t;
endpackage

interface rename_if;
  import rename_pkg::*;

  logic             in_valid;
  logic             in_ready;
  uop_t             uop_in;
  logic             out_valid;
  logic             out_ready;
  uop_t             uop_out;
  logic [PHY_W-1:0] out_old_prd;
  logic             commit_valid;
  logic [LOG_W-1:0] commit_rd;
  logic [PHY_W-1:0] commit_prd;
  logic [PHY_W-1:0] commit_old_prd;
  logic             flush;
  logic [PHY_W:0]   num_free;
  logic             full;

  modport master (
    output in_valid, uop_in, out_ready,
    output commit_valid, commit_rd,
    output commit_prd, commit_old_prd, flush,
    input  in_ready, out_valid, uop_out,
    input  out_old_prd, num_free, full
  );

  modport slave (
    input  in_valid, uop_in, out_ready,
    input  commit_valid, commit_rd,
    input  commit_prd, commit_old_prd, flush,
    output in_ready, out_valid, uop_out,
    output out_old_prd, num_free, full
  );
endinterface

// File: rtl/rename_unit.sv
// Register rename: speculative/committed maps, free bit-vector,
// commit-side release and single-cycle flush recovery.
module rename_unit
  import rename_pkg::*;
#(
  parameter int LOG_RF_DEPTH = LOG_DEPTH,
  parameter int PHY_RF_DEPTH = PHY_DEPTH
) (
  input logic    clk,
  input logic    rst,
  rename_if.slave io
);
  localparam int LW = $clog2(LOG_RF_DEPTH);
  localparam int PW = $clog2(PHY_RF_DEPTH);

  logic [LOG_RF_DEPTH-1:0][PW-1:0] spec_map;
  logic [LOG_RF_DEPTH-1:0][PW-1:0] spec_map_n;
  logic [LOG_RF_DEPTH-1:0][PW-1:0] commit_map;
  logic [LOG_RF_DEPTH-1:0][PW-1:0] commit_map_n;
  logic [PHY_RF_DEPTH-1:0] free_vec;
  logic [PHY_RF_DEPTH-1:0] free_n;
  logic [PHY_RF_DEPTH-1:0] commit_used;
  logic [PHY_RF_DEPTH-1:0] commit_used_n;

  logic          out_valid;
  uop_t          uop_out;
  uop_t          uop_n;
  logic [PW-1:0] old_prd;
  logic [PW-1:0] old_n;
  logic [PW-1:0] prd;
  logic [PW:0]   num_free;

  logic          fire;
  logic          alloc;
  logic          commit_en;
  logic [LW-1:0] rs1;
  logic [LW-1:0] rs2;
  logic [LW-1:0] rd;

  assign rs1 = io.uop_in.rs1[LW-1:0];
  assign rs2 = io.uop_in.rs2[LW-1:0];
  assign rd  = io.uop_in.rd[LW-1:0];

  assign io.in_ready = !rst
                     && (!out_valid || io.out_ready)
                     && !io.flush
                     && !io.full;

  assign fire  = io.in_valid && io.in_ready;
  assign alloc = fire && io.uop_in.rd_valid
               && rd != '0;
  assign commit_en = io.commit_valid
                   && io.commit_rd != '0;

  // lowest free register; bit 0 is never free
  always_comb begin
    prd = '0;
    for (int i = PHY_RF_DEPTH - 1; i > 0; i--)
      if (free_vec[i]) prd = PW'(i);
  end

  always_comb begin
    num_free = '0;
    for (int i = 0; i < PHY_RF_DEPTH; i++)
      num_free = num_free + (PW+1)'(free_vec[i]);
  end

  assign io.num_free = num_free;
  assign io.full     = num_free == '0;

  always_comb begin
    uop_n = io.uop_in;
    uop_n.rs1 = '0;
    uop_n.rs2 = '0;
    if (io.uop_in.rs1_valid && rs1 != '0)
      uop_n.rs1 = spec_map[rs1];
    if (io.uop_in.rs2_valid && rs2 != '0)
      uop_n.rs2 = spec_map[rs2];
    uop_n.rd = alloc ? prd : '0;
    old_n = alloc ? spec_map[rd] : '0;
  end

  // flush sees the committed state including a same-cycle commit
  always_comb begin
    commit_map_n  = commit_map;
    commit_used_n = commit_used;
    free_n        = free_vec;
    spec_map_n    = spec_map;
    if (commit_en) begin
      commit_map_n[io.commit_rd]      = io.commit_prd;
      commit_used_n[io.commit_prd]    = 1'b1;
      commit_used_n[io.commit_old_prd] = 1'b0;
      free_n[io.commit_old_prd]       = 1'b1;
    end
    if (alloc) begin
      free_n[prd]    = 1'b0;
      spec_map_n[rd] = prd;
    end
    if (io.flush) begin
      spec_map_n = commit_map_n;
      free_n     = ~commit_used_n;
    end
    free_n[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOG_RF_DEPTH; i++) begin
        spec_map[i]   <= PW'(i);
        commit_map[i] <= PW'(i);
      end
      for (int i = 0; i < PHY_RF_DEPTH; i++) begin
        free_vec[i]    <= (i >= LOG_RF_DEPTH);
        commit_used[i] <= (i < LOG_RF_DEPTH);
      end
    end else begin
      spec_map    <= spec_map_n;
      commit_map  <= commit_map_n;
      free_vec    <= free_n;
      commit_used <= commit_used_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      uop_out   <= '0;
      old_prd   <= '0;
    end else if (io.flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
      uop_out   <= uop_n;
      old_prd   <= old_n;
    end else if (io.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign io.out_valid   = out_valid;
  assign io.uop_out     = uop_out;
  assign io.out_old_prd = old_prd;
endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit with an expected-output queue
// and a small logical-to-physical map model.
module tb_rename_unit;
  import rename_pkg::*;

  typedef struct packed {
    uop_t             uop;
    logic [PHY_W-1:0] old;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rename_if bus ();

  rename_unit dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [PHY_W-1:0] smap [LOG_DEPTH];
  logic [PHY_W-1:0] cmap [LOG_DEPTH];

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LOG_DEPTH; i++) begin
      smap[i] = PHY_W'(i);
      cmap[i] = PHY_W'(i);
    end
    sb.delete();
  endtask

  function automatic uop_t mk(bit r1v, int r1, bit r2v,
                              int r2, bit rdv, int rd);
    uop_t u;
    u.imm       = 16'($urandom);
    u.op        = 6'($urandom);
    u.rs1_valid = r1v;
    u.rs1       = PHY_W'(r1);
    u.rs2_valid = r2v;
    u.rs2       = PHY_W'(r2);
    u.rd_valid  = rdv;
    u.rd        = PHY_W'(rd);
    return u;
  endfunction

  // drive one accepted uop; prd is the register the bench expects
  task automatic fire_uop(uop_t u, int prd);
    exp_t e;
    logic [LOG_W-1:0] l1, l2, ld;
    l1 = u.rs1[LOG_W-1:0];
    l2 = u.rs2[LOG_W-1:0];
    ld = u.rd[LOG_W-1:0];
    e.uop = u;
    e.uop.rs1 = (u.rs1_valid && l1 != 0) ? smap[l1] : '0;
    e.uop.rs2 = (u.rs2_valid && l2 != 0) ? smap[l2] : '0;
    if (u.rd_valid && ld != 0) begin
      e.uop.rd = PHY_W'(prd);
      e.old    = smap[ld];
      smap[ld] = PHY_W'(prd);
    end else begin
      e.uop.rd = '0;
      e.old    = '0;
    end
    sb.push_back(e);
    bus.in_valid = 1'b1;
    bus.uop_in   = u;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".valid"}, 64'(bus.out_valid), 64'(1));
      chk({tag, ".uop"}, 64'(bus.uop_out), 64'(e.uop));
      chk({tag, ".old"}, 64'(bus.out_old_prd), 64'(e.old));
    end
  endtask

  task automatic rename(uop_t u, int prd, string tag);
    fire_uop(u, prd);
    check_out(tag);
  endtask

  task automatic commit(int rd, int prd, int old);
    bus.commit_valid   = 1'b1;
    bus.commit_rd      = LOG_W'(rd);
    bus.commit_prd     = PHY_W'(prd);
    bus.commit_old_prd = PHY_W'(old);
    if (rd != 0) cmap[rd] = PHY_W'(prd);
    @(posedge clk);
    #1;
    bus.commit_valid = 1'b0;
  endtask

  // asserts rst between edges and checks outputs before any edge
  task automatic do_reset(string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, ".uop_out"}, 64'(bus.uop_out), 64'(0));
    chk({tag, ".old"}, 64'(bus.out_old_prd), 64'(0));
    chk({tag, ".num_free"}, 64'(bus.num_free), 64'(96));
    chk({tag, ".full"}, 64'(bus.full), 64'(0));
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(0));
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    uop_t u;
    int rd, prev;
    bus.in_valid       = 1'b0;
    bus.uop_in         = '0;
    bus.out_ready      = 1'b1;
    bus.commit_valid   = 1'b0;
    bus.commit_rd      = '0;
    bus.commit_prd     = '0;
    bus.commit_old_prd = '0;
    bus.flush          = 1'b0;
    model_reset();
    #1;
    do_reset("rst0");

    // first rename and dependent back-to-back uop
    rename(mk(1, 5, 0, 0, 1, 5), 32, "a");
    chk("a.num_free", 64'(bus.num_free), 64'(95));
    rename(mk(1, 5, 1, 0, 1, 5), 33, "b");
    chk("b.rs1", 64'(bus.uop_out.rs1), 64'(32));
    chk("b.rd", 64'(bus.uop_out.rd), 64'(33));
    chk("b.old", 64'(bus.out_old_prd), 64'(32));
    rename(mk(1, 5, 0, 0, 1, 0), 0, "rd0");
    rename(mk(0, 5, 0, 0, 0, 9), 0, "nordv");
    chk("nordv.num_free", 64'(bus.num_free), 64'(94));

    // exhaust the free list
    prev = 5;
    for (int i = 0; i < 94; i++) begin
      rd = 1 + (i % 31);
      rename(mk(1, prev, 0, 0, 1, rd), 34 + i, "exh");
      prev = rd;
    end
    chk("exh.num_free", 64'(bus.num_free), 64'(0));
    chk("exh.full", 64'(bus.full), 64'(1));
    chk("exh.in_ready", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b1;
    bus.uop_in   = mk(0, 0, 0, 0, 1, 4);
    #1;
    chk("full.in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("full.out_valid", 64'(bus.out_valid), 64'(0));
    chk("full.num_free", 64'(bus.num_free), 64'(0));
    commit(1, 32, 1);
    chk("rel.num_free", 64'(bus.num_free), 64'(1));
    chk("rel.full", 64'(bus.full), 64'(0));
    rename(mk(1, 0, 0, 0, 1, 2), 1, "rel");
    chk("rel2.num_free", 64'(bus.num_free), 64'(0));

    // backpressure
    do_reset("rst1");
    bus.out_ready = 1'b0;
    fire_uop(mk(0, 0, 0, 0, 1, 10), 32);
    u = mk(1, 10, 0, 0, 1, 11);
    bus.in_valid = 1'b1;
    bus.uop_in   = u;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp.in_ready", 64'(bus.in_ready), 64'(0));
      chk("bp.valid", 64'(bus.out_valid), 64'(1));
      chk("bp.uop", 64'(bus.uop_out), 64'(sb[0].uop));
      chk("bp.old", 64'(bus.out_old_prd), 64'(sb[0].old));
      chk("bp.num_free", 64'(bus.num_free), 64'(95));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    check_out("bp.a");
    rename(u, 33, "bp.b");
    chk("bp.rs1", 64'(bus.uop_out.rs1), 64'(32));
    chk("bp.end_free", 64'(bus.num_free), 64'(94));

    // flush with a same-cycle commit of the older uop
    do_reset("rst2");
    rename(mk(0, 0, 0, 0, 1, 3), 32, "f3");
    rename(mk(0, 0, 0, 0, 1, 4), 33, "f4");
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.uop_in   = mk(0, 0, 0, 0, 1, 8);
    bus.commit_valid   = 1'b1;
    bus.commit_rd      = LOG_W'(3);
    bus.commit_prd     = PHY_W'(32);
    bus.commit_old_prd = PHY_W'(3);
    cmap[3] = PHY_W'(32);
    #1;
    chk("fl.in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.commit_valid = 1'b0;
    for (int i = 0; i < LOG_DEPTH; i++) smap[i] = cmap[i];
    sb.delete();
    chk("fl.out_valid", 64'(bus.out_valid), 64'(0));
    chk("fl.num_free", 64'(bus.num_free), 64'(96));
    rename(mk(1, 3, 1, 4, 1, 4), 3, "fl.a");
    chk("fl.rs1", 64'(bus.uop_out.rs1), 64'(32));
    chk("fl.rs2", 64'(bus.uop_out.rs2), 64'(4));
    rename(mk(0, 0, 0, 0, 1, 6), 33, "fl.b");

    // asynchronous reset with an output in flight
    fire_uop(mk(0, 0, 0, 0, 1, 9), 34);
    chk("mid.valid", 64'(bus.out_valid), 64'(1));
    do_reset("rst3");
    rename(mk(1, 7, 0, 0, 1, 7), 32, "post");
    chk("post.old", 64'(bus.out_old_prd), 64'(7));
    chk("post.num_free", 64'(bus.num_free), 64'(95));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
